reg_initiator: RTL
==================

Name: reg_initiator

Overview:
- Bus master for the register access interface (addr / rd_wr / req / write_val / read_val / ack).
- Drives the responder-side register blocks, one transaction at a time.
- Accepts read/write commands over a valid/ready port and returns read data or a timeout error over a valid/ready response port.
- Sits between the host-side command source and the register file; also keeps sticky status and counters for debug.

Parameters:
ADDR_SIZE_P, 4, width of the register address bus.
TIMEOUT_P, 8, cycles in WAIT without ack before the transaction is errored; legal range 1..255.
CNT_W_P, 16, width of the transaction and timeout counters.

Ports:
clk  input  1  single clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
cmd_rd_wr  input  1  1 = read, 0 = write.
cmd_addr  input  ADDR_SIZE_P  target register address.
cmd_wdata  input  32  write data; ignored for reads.
rsp_valid  output  1  response present.
rsp_ready  input  1  response consumed when rsp_valid && rsp_ready.
rsp_rd_wr  output  1  echo of command type.
rsp_rdata  output  32  read data; 0 for writes and timeouts.
rsp_err  output  1  1 = transaction timed out.
req  output  1  bus request, one-cycle pulse.
rd_wr  output  1  bus direction: 1 = read, 0 = write.
addr  output  ADDR_SIZE_P  bus address.
write_val  output  32  bus write data.
read_val  input  32  bus read data; valid when ack = 1.
ack  input  1  bus acknowledge.
txn_cnt  output  CNT_W_P  completed transactions (ok or err); saturates at all-ones.
timeout_cnt  output  CNT_W_P  timed-out transactions; saturates.
spurious_ack  output  1  sticky; ack seen outside WAIT.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high (port reset).
- Reset values: all outputs 0, counters 0, FSM in IDLE. cmd_ready goes to 1 the first cycle after reset deasserts.
- Reset mid-transaction:
  - Aborts the transaction immediately at the next edge.
  - No response is produced and counters are not updated.
  - req, addr, rd_wr and write_val return to 0.
- FSM states: IDLE, REQ, WAIT, RSP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch cmd_rd_wr, cmd_addr and cmd_wdata (cmd_wdata forced to 0 for reads) and go to REQ.
- REQ:
  - req = 1 for exactly this cycle; addr, rd_wr and write_val driven from the latched command.
  - Next state is WAIT unconditionally.
  - An ack in this cycle is spurious.
- WAIT:
  - req = 0; addr, rd_wr and write_val held stable.
  - The wait counter starts at 1 on the first WAIT cycle.
  - If ack = 1: capture read_val into rsp_rdata when reading (0 when writing), set rsp_err = 0, go to RSP.
  - If there is no ack and wait counter == TIMEOUT_P: set rsp_err = 1 and rsp_rdata = 0, go to RSP.
  - Otherwise increment the wait counter.
  - ack and timeout in the same cycle: ack wins.
- RSP:
  - rsp_valid = 1; rsp fields are stable until the handshake.
  - Bus outputs return to 0.
  - On rsp_ready: increment txn_cnt, increment timeout_cnt if rsp_err, go to IDLE.
  - Back-pressure may be indefinite; cmd_ready stays 0 throughout.
- Throughput and latency:
  - The responder acks in the cycle after req. With cmd accepted at edge T, req is high in T+1, ack arrives in T+2, and rsp_valid is high in T+3.
  - Back-to-back commands therefore take a minimum of 4 cycles each.
  - rsp_ready held high returns the block to IDLE at the next edge.
- Spurious ack: ack = 1 in IDLE, REQ or RSP sets spurious_ack, which stays set until reset. It has no other effect.
- Counters: saturate at 2^CNT_W_P - 1 and never wrap.
- Only one transaction is outstanding; there is no command buffering.

Test Plan:
- Write: cmd (rd_wr=0, addr=1, wdata=0x0000_0005), responder acks 1 cycle after req -> req pulse 1 cycle with addr=1, write_val=5, rd_wr=0; rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0; txn_cnt=1.
- Read: cmd (rd_wr=1, addr=0), responder returns read_val=0x0000_0013 with ack -> rsp_rdata=0x13, rsp_rd_wr=1, write_val=0 throughout.
- Timeout: TIMEOUT_P=8, responder never acks -> rsp_valid with rsp_err=1 exactly 9 cycles after req; timeout_cnt=1, txn_cnt=1; next command accepted normally.
- Back-pressure and back-to-back: cmd_valid held high with 3 queued commands, rsp_ready low 5 cycles on the first -> cmd_ready=0 and rsp fields stable during stall; 3 responses returned in order with correct data.
- Boundaries: ack on the exact cycle wait counter == TIMEOUT_P -> rsp_err=0. Ack injected in IDLE -> spurious_ack=1 and no FSM change. Preload txn_cnt near max with CNT_W_P=2 -> holds at 3.
- Reset mid-WAIT: reset asserted 2 cycles after req -> next edge shows rsp_valid=0, req=0, addr=0, counters unchanged; cmd_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/reg_initiator.sv
// Single-outstanding register-bus master: command in, one req pulse, ack or timeout, response out.
// Latency: accept -> req next cycle -> rsp_valid 2+wait cycles later; stalls indefinitely on rsp_ready.
module reg_initiator #(
  parameter int ADDR_SIZE_P = 4,
  parameter int TIMEOUT_P   = 8,
  parameter int CNT_W_P     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_rd_wr,
  input  logic [ADDR_SIZE_P-1:0] cmd_addr,
  input  logic [31:0]            cmd_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_rd_wr,
  output logic [31:0]            rsp_rdata,
  output logic                   rsp_err,
  output logic                   req,
  output logic                   rd_wr,
  output logic [ADDR_SIZE_P-1:0] addr,
  output logic [31:0]            write_val,
  input  logic [31:0]            read_val,
  input  logic                   ack,
  output logic [CNT_W_P-1:0]     txn_cnt,
  output logic [CNT_W_P-1:0]     timeout_cnt,
  output logic                   spurious_ack
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_t;

  state_t                 state, state_nxt;
  logic [7:0]             wait_cnt;
  logic                   lat_rd_wr;
  logic [ADDR_SIZE_P-1:0] lat_addr;
  logic [31:0]            lat_wdata;
  logic [31:0]            rdata_q;
  logic                   err_q;
  logic                   timed_out;

  assign timed_out = (wait_cnt == 8'(TIMEOUT_P));

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rd_wr = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    req       = 1'b0;
    rd_wr     = 1'b0;
    addr      = '0;
    write_val = '0;
    case (state)
      IDLE: begin
        // Gated with reset so the port reads 0 for the whole reset period.
        cmd_ready = !reset;
        if (cmd_valid && !reset) state_nxt = REQ;
      end
      REQ: begin
        req       = 1'b1;
        rd_wr     = lat_rd_wr;
        addr      = lat_addr;
        write_val = lat_wdata;
        state_nxt = WAIT;
      end
      WAIT: begin
        rd_wr     = lat_rd_wr;
        addr      = lat_addr;
        write_val = lat_wdata;
        if (ack || timed_out) state_nxt = RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        rsp_rd_wr = lat_rd_wr;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      lat_rd_wr <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            lat_rd_wr <= cmd_rd_wr;
            lat_addr  <= cmd_addr;
            lat_wdata <= cmd_rd_wr ? 32'd0 : cmd_wdata;
          end
        end
        REQ: wait_cnt <= 8'd1;
        WAIT: begin
          // An ack on the final wait cycle still completes normally.
          if (ack) begin
            rdata_q <= lat_rd_wr ? read_val : 32'd0;
            err_q   <= 1'b0;
          end else if (timed_out) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      txn_cnt      <= '0;
      timeout_cnt  <= '0;
      spurious_ack <= 1'b0;
    end else begin
      if (state == RSP && rsp_ready) begin
        if (txn_cnt != '1) txn_cnt <= txn_cnt + CNT_W_P'(1);
        if (err_q && timeout_cnt != '1) timeout_cnt <= timeout_cnt + CNT_W_P'(1);
      end
      if (ack && state != WAIT) spurious_ack <= 1'b1;
    end
  end

endmodule
